// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command responder.
// Holds the frame constants, reply status codes, parser/responder state
// enums and the request checksum helper.
package uart_cmd_pkg;

    localparam logic [7:0] SOF_REQ      = 8'hA5;
    localparam logic [7:0] SOF_RSP      = 8'h5A;
    localparam logic [7:0] CMD_SET_NOTE = 8'h01;
    localparam logic [7:0] CMD_GET_NOTE = 8'h02;

    localparam logic [7:0] ST_OK  = 8'h00;
    localparam logic [7:0] ST_CHK = 8'hE0;
    localparam logic [7:0] ST_CMD = 8'hE1;

    typedef enum logic [1:0] {
        P_IDLE,
        P_CMD,
        P_DATA,
        P_CHK
    } parser_state_t;

    typedef enum logic [2:0] {
        R_IDLE,
        R_HDR,
        R_STAT,
        R_DATA,
        R_TAIL
    } resp_state_t;

    // Request checksum: CHK = CMD ^ DATA.
    function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] data);
        return cmd ^ data;
    endfunction

endpackage

// File: rtl/uart_tx_pacer.sv
// Reply pacer: buffers a 3-byte reply (0x5A, status, data) and emits it as
// tx_data_valid pulses spaced exactly TX_GAP cycles apart, then holds busy
// for TX_GAP cycles after the last pulse.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            one-cycle request; accepted only in R_IDLE
//   status, data     reply payload captured on start
//   tx_data_valid    one-cycle transmit pulse
//   tx_data_out      byte to transmit, held until the next pulse
//   busy             high from the cycle after start until return to R_IDLE
//   state            current responder state (debug / checker visibility)
//
// Handshake: start is a fire-and-forget pulse. The header pulse appears on
// the cycle after start; the transmitter has no ready/busy so pacing is
// purely by counting cycles.
import uart_cmd_pkg::*;

module uart_tx_pacer #(
    parameter int TX_GAP = 120,
    parameter int CNT_W  = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  status,
    input  logic [7:0]  data,
    output logic        tx_data_valid,
    output logic [7:0]  tx_data_out,
    output logic        busy,
    output resp_state_t state
);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(TX_GAP - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(TX_GAP);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // cnt is cleared on every pulse, so during the gap it reads the number of
    // cycles elapsed since the most recent pulse.
    logic [CNT_W-1:0] cnt;
    logic [7:0]       buf_stat;
    logic [7:0]       buf_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= R_IDLE;
            cnt           <= '0;
            buf_stat      <= '0;
            buf_data      <= '0;
            tx_data_valid <= 1'b0;
            tx_data_out   <= '0;
            busy          <= 1'b0;
        end else begin
            tx_data_valid <= 1'b0;
            cnt           <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            case (state)
                R_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        buf_stat      <= status;
                        buf_data      <= data;
                        tx_data_valid <= 1'b1;
                        tx_data_out   <= SOF_RSP;
                        busy          <= 1'b1;
                        state         <= R_HDR;
                    end
                end
                R_HDR: begin
                    if (cnt == GAP_LAST) begin
                        tx_data_valid <= 1'b1;
                        tx_data_out   <= buf_stat;
                        cnt           <= '0;
                        state         <= R_STAT;
                    end
                end
                R_STAT: begin
                    if (cnt == GAP_LAST) begin
                        tx_data_valid <= 1'b1;
                        tx_data_out   <= buf_data;
                        cnt           <= '0;
                        state         <= R_DATA;
                    end
                end
                // R_DATA covers the cycle of the last pulse; the trailing
                // gap is then timed in R_TAIL until TX_GAP cycles have passed.
                R_DATA: begin
                    state <= R_TAIL;
                end
                R_TAIL: begin
                    if (cnt == GAP_END) begin
                        busy  <= 1'b0;
                        state <= R_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// Command responder above the UART byte bus. Parses 4-byte request frames
// (0xA5, CMD, DATA, CHK with CHK = CMD ^ DATA), maintains the note register
// and returns a 3-byte reply (0x5A, status, data) through uart_tx_pacer.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rx_data_valid   one-cycle pulse qualifying rx_data_in
//   rx_data_in      received byte
//   tx_data_valid   one-cycle transmit pulse
//   tx_data_out     byte to transmit
//   note_code       current note register
//   note_update     one-cycle pulse when note_code is set by command
//   frame_err       one-cycle pulse on inter-byte timeout or busy drop
//   busy            reply in progress, including the trailing gap
import uart_cmd_pkg::*;

module uart_cmd_responder #(
    parameter int BPS_PARA   = 10,
    parameter int TX_GAP     = 120,
    parameter int RX_TIMEOUT = 400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_data_valid,
    input  logic [7:0] rx_data_in,
    output logic       tx_data_valid,
    output logic [7:0] tx_data_out,
    output logic [7:0] note_code,
    output logic       note_update,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = $clog2((TX_GAP > RX_TIMEOUT) ? TX_GAP : RX_TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RX_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // The pacer needs 10 bit times per byte plus margin between pulses.
    if (TX_GAP < 12 * BPS_PARA) begin : g_gap_check
        $error("TX_GAP too small for BPS_PARA");
    end

    parser_state_t    pstate;
    resp_state_t      resp_state;
    logic [7:0]       cmd_q;
    logic [7:0]       data_q;
    logic [CNT_W-1:0] to_cnt;

    logic       frame_done;
    logic       chk_ok;
    logic       accept;
    logic       set_note;
    logic [7:0] rsp_status;
    logic [7:0] rsp_data;

    // The CHK byte is evaluated on the cycle it arrives, against the
    // latched CMD/DATA. A frame is only accepted while the pacer is idle.
    assign frame_done = rx_data_valid && (pstate == P_CHK);
    assign chk_ok     = (frame_chk(cmd_q, data_q) == rx_data_in);
    assign accept     = frame_done && (resp_state == R_IDLE);

    always_comb begin
        rsp_status = ST_OK;
        rsp_data   = '0;
        set_note   = 1'b0;
        if (!chk_ok) begin
            rsp_status = ST_CHK;
        end else begin
            case (cmd_q)
                CMD_SET_NOTE: begin
                    rsp_data = data_q;
                    set_note = 1'b1;
                end
                CMD_GET_NOTE: rsp_data = note_code;
                default: begin
                    rsp_status = ST_CMD;
                    rsp_data   = cmd_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pstate      <= P_IDLE;
            cmd_q       <= '0;
            data_q      <= '0;
            to_cnt      <= '0;
            note_code   <= '0;
            note_update <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            note_update <= 1'b0;
            frame_err   <= 1'b0;
            if (rx_data_valid) begin
                to_cnt <= '0;
                case (pstate)
                    P_IDLE: if (rx_data_in == SOF_REQ) pstate <= P_CMD;
                    P_CMD: begin
                        cmd_q  <= rx_data_in;
                        pstate <= P_DATA;
                    end
                    P_DATA: begin
                        data_q <= rx_data_in;
                        pstate <= P_CHK;
                    end
                    P_CHK: begin
                        pstate <= P_IDLE;
                        if (!accept) begin
                            frame_err <= 1'b1;
                        end else if (set_note) begin
                            // Lands on the same cycle as the 0x5A header pulse.
                            note_code   <= data_q;
                            note_update <= 1'b1;
                        end
                    end
                    default: pstate <= P_IDLE;
                endcase
            end else if (pstate == P_IDLE) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
                to_cnt    <= '0;
                pstate    <= P_IDLE;
                frame_err <= 1'b1;
            end else begin
                to_cnt <= (to_cnt == CNT_MAX) ? to_cnt : to_cnt + 1'b1;
            end
        end
    end

    uart_tx_pacer #(
        .TX_GAP (TX_GAP),
        .CNT_W  (CNT_W)
    ) u_pacer (
        .clk           (clk),
        .rst           (rst),
        .start         (accept),
        .status        (rsp_status),
        .data          (rsp_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_out   (tx_data_out),
        .busy          (busy),
        .state         (resp_state)
    );

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: request frames in, paced reply
// bytes, note register, frame_err and busy timing checked against
// hand-computed values.
module tb_uart_cmd_responder;

    localparam int TX_GAP     = 120;
    localparam int RX_TIMEOUT = 400;

    // clock / reset
    logic       clk = 1'b0;
    logic       rst;
    logic       rx_data_valid;
    logic [7:0] rx_data_in;
    logic       tx_data_valid;
    logic [7:0] tx_data_out;
    logic [7:0] note_code;
    logic       note_update;
    logic       frame_err;
    logic       busy;

    always #5 clk = ~clk;

    uart_cmd_responder #(
        .BPS_PARA   (10),
        .TX_GAP     (TX_GAP),
        .RX_TIMEOUT (RX_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data_valid (rx_data_valid),
        .rx_data_in    (rx_data_in),
        .tx_data_valid (tx_data_valid),
        .tx_data_out   (tx_data_out),
        .note_code     (note_code),
        .note_update   (note_update),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    int checks = 0;
    int errors = 0;

    // monitor: event log sampled on the falling edge
    int         cyc = 0;
    int         last_rx_cyc = 0;
    logic [7:0] txb_q[$];
    int         txc_q[$];
    int         nu_cnt = 0;
    int         nu_cyc = 0;
    logic [7:0] nu_note = 8'h00;
    int         fe_cnt = 0;
    int         fe_cyc = 0;
    logic       busy_prev = 1'b0;
    int         busy_rise_cyc = 0;
    int         busy_fall_cyc = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rx_data_valid === 1'b1) last_rx_cyc = cyc;
        if (tx_data_valid === 1'b1) begin
            txb_q.push_back(tx_data_out);
            txc_q.push_back(cyc);
        end
        if (note_update === 1'b1) begin
            nu_cnt  = nu_cnt + 1;
            nu_cyc  = cyc;
            nu_note = note_code;
        end
        if (frame_err === 1'b1) begin
            fe_cnt = fe_cnt + 1;
            fe_cyc = cyc;
        end
        if (!busy_prev && busy === 1'b1) busy_rise_cyc = cyc;
        if (busy_prev && busy === 1'b0) busy_fall_cyc = cyc;
        busy_prev = (busy === 1'b1);
    end

    // scoreboard
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data_valid = 1'b1;
        rx_data_in    = b;
        @(posedge clk);
        #1;
        rx_data_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    task automatic expect_reply(input string tag, input logic [7:0] st, input logic [7:0] dt,
                                input int chk_cyc);
        int c_prev;
        int c;
        logic [7:0] b;
        exp_q.push_back(8'h5A);
        exp_q.push_back(st);
        exp_q.push_back(dt);
        for (int i = 0; i < 3 * TX_GAP + 20; i++) begin
            if (txb_q.size() >= 3) break;
            @(negedge clk);
            #1;
        end
        check({tag, "_tx_count"}, txb_q.size(), 3);
        c_prev = chk_cyc;
        for (int k = 0; k < 3; k++) begin
            if (txb_q.size() == 0) begin
                void'(exp_q.pop_front());
            end else begin
                b = txb_q.pop_front();
                c = txc_q.pop_front();
                check({tag, "_byte"}, b, exp_q.pop_front());
                check({tag, "_spacing"}, c - c_prev, (k == 0) ? 1 : TX_GAP);
                c_prev = c;
            end
        end
        for (int i = 0; i < TX_GAP + 20; i++) begin
            if (busy_fall_cyc > c_prev) break;
            @(negedge clk);
            #1;
        end
        check({tag, "_busy_rise"}, busy_rise_cyc, chk_cyc + 1);
        check({tag, "_busy_fall"}, busy_fall_cyc, c_prev + TX_GAP + 1);
    endtask

    initial begin
        int nb;
        int fb;
        int chk1;
        int chk2;
        int b_cyc;

        rst           = 1'b1;
        rx_data_valid = 1'b0;
        rx_data_in    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cycles(1);

        // reset state
        check("rst_tx_valid", tx_data_valid, 0);
        check("rst_tx_out", tx_data_out, 8'h00);
        check("rst_note", note_code, 8'h00);
        check("rst_note_update", note_update, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);

        // 1: set note 0x3C
        nb = nu_cnt;
        send_frame(8'hA5, 8'h01, 8'h3C, 8'h3D);
        chk1 = last_rx_cyc;
        expect_reply("t1", 8'h00, 8'h3C, chk1);
        check("t1_nu_count", nu_cnt - nb, 1);
        check("t1_nu_cycle", nu_cyc, chk1 + 1);
        check("t1_nu_note", nu_note, 8'h3C);
        check("t1_note", note_code, 8'h3C);

        // 2: get note
        nb = nu_cnt;
        send_frame(8'hA5, 8'h02, 8'h00, 8'h02);
        expect_reply("t2", 8'h00, 8'h3C, last_rx_cyc);
        check("t2_nu_none", nu_cnt - nb, 0);

        // 3: bad checksum on a set command, note must not move
        nb = nu_cnt;
        send_frame(8'hA5, 8'h01, 8'h44, 8'h00);
        expect_reply("t3", 8'hE0, 8'h00, last_rx_cyc);
        check("t3_note", note_code, 8'h3C);
        check("t3_nu_none", nu_cnt - nb, 0);

        // 4: unknown command, then stray bytes
        send_frame(8'hA5, 8'h07, 8'h10, 8'h17);
        expect_reply("t4", 8'hE1, 8'h07, last_rx_cyc);
        fb = fe_cnt;
        send_byte(8'h11);
        send_byte(8'h22);
        wait_cycles(40);
        check("t4_stray_tx", txb_q.size(), 0);
        check("t4_stray_err", fe_cnt - fb, 0);
        check("t4_stray_busy", busy, 0);

        // 5: inter-byte timeout, then a valid frame
        fb = fe_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        b_cyc = last_rx_cyc;
        wait_cycles(RX_TIMEOUT + 20);
        check("t5_err_count", fe_cnt - fb, 1);
        check("t5_err_cycle", fe_cyc, b_cyc + RX_TIMEOUT + 1);
        check("t5_no_tx", txb_q.size(), 0);
        nb = nu_cnt;
        send_frame(8'hA5, 8'h01, 8'h55, 8'h54);
        expect_reply("t5", 8'h00, 8'h55, last_rx_cyc);
        check("t5_note", note_code, 8'h55);
        check("t5_nu_count", nu_cnt - nb, 1);

        // 6a: frame completing while busy is dropped
        fb = fe_cnt;
        nb = nu_cnt;
        send_frame(8'hA5, 8'h02, 8'h00, 8'h02);
        chk1 = last_rx_cyc;
        send_frame(8'hA5, 8'h01, 8'h77, 8'h76);
        chk2 = last_rx_cyc;
        expect_reply("t6", 8'h00, 8'h55, chk1);
        check("t6_drop_err", fe_cnt - fb, 1);
        check("t6_drop_err_cycle", fe_cyc, chk2 + 1);
        check("t6_drop_note", note_code, 8'h55);
        check("t6_drop_nu", nu_cnt - nb, 0);
        wait_cycles(20);
        check("t6_drop_tx", txb_q.size(), 0);

        // 6b: reset between the first and second reply pulses
        send_frame(8'hA5, 8'h01, 8'h3C, 8'h3D);
        wait_cycles(10);
        check("t6r_hdr_seen", txb_q.size(), 1);
        check("t6r_note_pre", note_code, 8'h3C);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6r_note_post", note_code, 8'h00);
        check("t6r_busy_post", busy, 0);
        wait_cycles(3 * TX_GAP);
        check("t6r_no_more_tx", txb_q.size(), 1);
        if (txb_q.size() > 0) check("t6r_hdr_byte", txb_q.pop_front(), 8'h5A);
        check("t6r_busy_end", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
